// File: rtl/led_scan_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | led_scan_pkg                                                               |
// | Shared types and helpers for the multiplexed LED scan driver:              |
// |   scan_state_e - per-slot FSM state (BLANK dead time, SHOW lit time)       |
// |   blank_seg()  - all-ones (every segment off) pattern, sliced by the user  |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package led_scan_pkg;

  typedef enum logic [0:0] {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_e;

  // Widest segment bus the helper can serve; callers cast down to SEG_W.
  localparam int MAX_SEG_W = 64;

  // Segments are active-low, so "all off" is all ones.
  function automatic logic [MAX_SEG_W-1:0] blank_seg();
    return '1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_digit_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | led_digit_mux                                                              |
// | Combinational digit selector: returns the active-low pattern of the digit  |
// | whose one-hot sel bit is set, or all ones (dark) when sel is zero.         |
// | Ports:                                                                     |
// |   sel    in  DIGITS        one-hot digit enable (or zero)                   |
// |   active in  DIGITS*SEG_W  frame, digit i at [i*SEG_W +: SEG_W]             |
// |   seg_n  out SEG_W         selected active-low segments                    |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module led_digit_mux
  import led_scan_pkg::*;
#(
  parameter int DIGITS = 6,
  parameter int SEG_W  = 8
) (
  input  logic [DIGITS-1:0]       sel,
  input  logic [DIGITS*SEG_W-1:0] active,
  output logic [SEG_W-1:0]        seg_n
);

  localparam logic [SEG_W-1:0] SEG_OFF = SEG_W'(blank_seg());

  // Active-low patterns merge with AND, so a zero sel leaves everything dark.
  always_comb begin
    seg_n = SEG_OFF;
    for (int i = 0; i < DIGITS; i++) begin
      if (sel[i]) begin
        seg_n = seg_n & active[i*SEG_W +: SEG_W];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/led_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | led_scan_driver                                                            |
// | Time-multiplexed LED digit scanner with a double-buffered frame. Each      |
// | digit slot is SCAN_DIV cycles: BLANK_CYC dark cycles, then the digit lit.  |
// | A new frame is parked in a pending buffer and only copied to the active    |
// | buffer at the start of digit 0's slot, so a frame is never torn.           |
// | Ports:                                                                     |
// |   clk, rst     clock, synchronous active-high reset                        |
// |   brightness   4-bit dimming level (only with LEDSCAN_DIMMING_EN)          |
// |   in_valid/in_ready/in_data  frame offer handshake                         |
// |   sel          one-hot digit enable, zero while blanked                    |
// |   seg_n        active-low segments of the enabled digit                    |
// |   frame_start  one-cycle pulse as digit 0's slot begins                    |
// | Optional feature macro: LEDSCAN_DIMMING_EN                                 |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module led_scan_driver
  import led_scan_pkg::*;
#(
  parameter int DIGITS    = 6,
  parameter int SEG_W     = 8,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef LEDSCAN_DIMMING_EN
  input  logic [3:0]              brightness,
`endif
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DIGITS*SEG_W-1:0] in_data,
  output logic [DIGITS-1:0]       sel,
  output logic [SEG_W-1:0]        seg_n,
  output logic                    frame_start
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);
  localparam logic [SEG_W-1:0] SEG_OFF    = SEG_W'(blank_seg());
  localparam logic [DIGITS*SEG_W-1:0] FRAME_OFF = {DIGITS{SEG_OFF}};

  scan_state_e             state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    run_q, run_d;
  logic                    pending_full_q, pending_full_d;
  logic [DIGITS*SEG_W-1:0] pending_q, pending_d;
  logic [DIGITS*SEG_W-1:0] active_q, active_d;
  logic [DIGITS-1:0]       sel_q, sel_d;
  logic [SEG_W-1:0]        seg_n_q, seg_n_d;
  logic                    frame_start_q, frame_start_d;
  logic                    lit_d;
  logic                    accept;
  logic                    swap;

  // Slot position. run_q is low only in the first edge out of reset, which
  // holds the position at digit 0 / count 0 so that the first visible cycle
  // after reset is the opening BLANK cycle of a frame.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    run_d   = 1'b1;
    if (!run_q) begin
      state_d = BLANK;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      case (state_q)
        BLANK:   if (cnt_q == BLANK_LAST) state_d = SHOW;
        SHOW:    if (cnt_q == CNT_LAST)   state_d = BLANK;
        default: state_d = BLANK;
      endcase
    end
  end

`ifdef LEDSCAN_DIMMING_EN
  logic [3:0]  bright_q, bright_d;
  logic [31:0] lit_limit;
  logic [31:0] show_cnt;

  // Brightness is captured in the first cycle of each slot and held for the
  // rest of it. show_cnt underflows during BLANK, which is harmless because
  // sel is gated by the SHOW state.
  always_comb begin
    bright_d  = (run_q && (cnt_q == '0)) ? brightness : bright_q;
    lit_limit = (32'(SCAN_DIV - BLANK_CYC) * (32'(bright_d) + 32'd1)) >> 4;
    show_cnt  = 32'(cnt_d) - 32'(BLANK_CYC);
    lit_d     = (show_cnt < lit_limit);
  end

  always_ff @(posedge clk) begin
    if (rst) bright_q <= 4'hF;
    else     bright_q <= bright_d;
  end
`else
  always_comb begin
    lit_d = 1'b1;
  end
`endif

  assign in_ready = !pending_full_q && !rst;

  // Frame buffers and registered outputs. frame_start_q marks the cycle in
  // which the swap happens, so the swap and the pulse always coincide.
  // Accept and swap are mutually exclusive: one needs pending empty, the
  // other pending full.
  always_comb begin
    accept         = in_valid && in_ready;
    swap           = frame_start_q && pending_full_q;
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    active_d       = active_q;
    if (swap) begin
      active_d       = pending_q;
      pending_full_d = 1'b0;
    end else if (accept) begin
      pending_d      = in_data;
      pending_full_d = 1'b1;
    end
    frame_start_d = (cnt_d == '0) && (idx_d == '0);
    sel_d         = ((state_d == SHOW) && lit_d) ? (DIGITS'(1) << idx_d) : '0;
  end

  led_digit_mux #(
    .DIGITS (DIGITS),
    .SEG_W  (SEG_W)
  ) u_digit_mux (
    .sel    (sel_d),
    .active (active_q),
    .seg_n  (seg_n_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= BLANK;
      cnt_q          <= '0;
      idx_q          <= '0;
      run_q          <= 1'b0;
      pending_full_q <= 1'b0;
      pending_q      <= FRAME_OFF;
      active_q       <= FRAME_OFF;
      sel_q          <= '0;
      seg_n_q        <= SEG_OFF;
      frame_start_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      run_q          <= run_d;
      pending_full_q <= pending_full_d;
      pending_q      <= pending_d;
      active_q       <= active_d;
      sel_q          <= sel_d;
      seg_n_q        <= seg_n_d;
      frame_start_q  <= frame_start_d;
    end
  end

  assign sel         = sel_q;
  assign seg_n       = seg_n_q;
  assign frame_start = frame_start_q;

endmodule
`default_nettype wire
